// File: rtl/div_32_seq.sv
`default_nettype none
// ============================================================================
// Module   : div_32_seq
// Brief    : Iterative restoring divider, signed/unsigned, one quotient bit
//            per clock, start/busy/done handshake with registered results.
// Revision : 1.0 - initial release
// ============================================================================
module div_32_seq #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         signed_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int           c_cnt_w = $clog2(W + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(W - 1);
    localparam logic [W-1:0] c_min   = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    // Working registers: r_dvd shifts the dividend out at the top while the
    // quotient bits enter at the bottom, so it ends up holding |q|.
    logic [W-1:0]       r_dvd;
    logic [W-1:0]       r_rem;
    logic [W-1:0]       r_bmag;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_q_neg;
    logic               r_r_neg;
    logic               r_dz;
    logic               r_ov;

    logic               w_accept;
    logic [W-1:0]       w_a_mag;
    logic [W-1:0]       w_b_mag;
    logic               w_is_zero;
    logic               w_is_ovf;
    logic [W:0]         w_rem_sh;
    logic [W:0]         w_trial;
    logic               w_borrow;

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_a_mag   = (signed_in && a[W-1]) ? -a : a;
    assign w_b_mag   = (signed_in && b[W-1]) ? -b : b;
    assign w_is_zero = (b == '0);
    assign w_is_ovf  = signed_in && (a == c_min) && (b == '1);

    // Trial subtraction is one bit wider so the top bit is the borrow.
    assign w_rem_sh  = {r_rem, r_dvd[W-1]};
    assign w_trial   = w_rem_sh - {1'b0, r_bmag};
    assign w_borrow  = w_trial[W];

    assign busy      = (r_state != S_IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; fast paths skip CALC entirely.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (w_is_zero || w_is_ovf) ? S_FIN : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == c_last) begin
                    w_next = S_FIN;
                end
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture at acceptance and one restoring iteration per CALC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd   <= '0;
            r_rem   <= '0;
            r_bmag  <= '0;
            r_cnt   <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_dz    <= 1'b0;
            r_ov    <= 1'b0;
        end else if (w_accept) begin
            r_bmag <= w_b_mag;
            r_cnt  <= '0;
            r_dz   <= w_is_zero;
            r_ov   <= w_is_ovf;
            if (w_is_zero) begin
                // Final values preloaded raw; no sign fix on the way out.
                r_dvd   <= '1;
                r_rem   <= a;
                r_q_neg <= 1'b0;
                r_r_neg <= 1'b0;
            end else if (w_is_ovf) begin
                r_dvd   <= a;
                r_rem   <= '0;
                r_q_neg <= 1'b0;
                r_r_neg <= 1'b0;
            end else begin
                r_dvd   <= w_a_mag;
                r_rem   <= '0;
                r_q_neg <= signed_in && (a[W-1] ^ b[W-1]);
                r_r_neg <= signed_in && a[W-1];
            end
        end else if (r_state == S_CALC) begin
            r_rem <= w_borrow ? w_rem_sh[W-1:0] : w_trial[W-1:0];
            r_dvd <= {r_dvd[W-2:0], ~w_borrow};
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Result registers load only in FIN and hold otherwise; done pulses once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= (r_state == S_FIN);
            if (r_state == S_FIN) begin
                quotient    <= r_q_neg ? -r_dvd : r_dvd;
                remainder   <= r_r_neg ? -r_rem : r_rem;
                div_by_zero <= r_dz;
                overflow    <= r_ov;
            end
        end
    end

endmodule
`default_nettype wire
